coin_return_dispenser: RTL and testbench

Returns the customer's outstanding balance as physical coins once the vending machine's inactivity countdown expires or an explicit return is requested. It sits between the wait-time counter and main balance FSM on one side and the coin hopper on the other. It latches the balance, clears it upstream, and issues coins largest-denomination-first over a one-coin-at-a-time valid/ack handshake.

---
 rtl/coin_return_dispenser_if.sv | 26 ++
 rtl/coin_return_dispenser.sv | 132 +++++++++++++
 tb/tb_coin_return_dispenser.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/coin_return_dispenser_if.sv
// Dispenser-side bundle: trigger/balance inputs from upstream, coin handshake and
// status toward the hopper. The design uses the slave modport; the driver uses master.
interface coin_return_dispenser_if #(
  parameter int unsigned NUM_COINS = 3
);
  logic [31:0]          i_wait_time;
  logic                 i_return_req;
  logic [31:0]          i_balance;
  logic                 i_coin_ack;
  logic [NUM_COINS-1:0] o_return_coin;
  logic                 o_clear_balance;
  logic                 o_busy;
  logic                 o_done;
  logic [31:0]          o_residue;
  logic                 o_fault;

  modport master (
    output i_wait_time, i_return_req, i_balance, i_coin_ack,
    input  o_return_coin, o_clear_balance, o_busy, o_done, o_residue, o_fault
  );

  modport slave (
    input  i_wait_time, i_return_req, i_balance, i_coin_ack,
    output o_return_coin, o_clear_balance, o_busy, o_done, o_residue, o_fault
  );
endinterface

// File: rtl/coin_return_dispenser.sv
// Latches the customer balance on timeout/return request and pays it out largest coin first.
// Optional macro RETURN_ACK_TIMEOUT_EN aborts a return when the hopper stops acknowledging.
module coin_return_dispenser #(
  parameter int unsigned NUM_COINS   = 3,
  parameter int unsigned COIN0_VALUE = 100,
  parameter int unsigned COIN1_VALUE = 500,
  parameter int unsigned COIN2_VALUE = 1000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input logic                      clk,
  input logic                      reset_n,
  coin_return_dispenser_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, LOAD, SELECT, WAIT_ACK, DONE} state_t;

  // Ascending order is relied on by the coin picker below.
  localparam logic [31:0] COIN_VAL [NUM_COINS] = '{32'(COIN0_VALUE), 32'(COIN1_VALUE),
                                                   32'(COIN2_VALUE)};

  state_t               state, state_nx;
  logic [31:0]          rem, rem_nx;
  logic [31:0]          residue, residue_nx;
  logic [NUM_COINS-1:0] sel, sel_nx;
  logic [NUM_COINS-1:0] pick;
  logic [31:0]          sel_val;
  logic                 fault_q, fault_nx;
  logic                 timeout;
  logic                 trigger;

  assign trigger = (bus.i_wait_time == 32'd0 || bus.i_return_req) && bus.i_balance != 32'd0;

  always_comb begin
    pick    = '0;
    sel_val = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (rem >= COIN_VAL[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
      if (sel[i]) sel_val = COIN_VAL[i];
    end
  end

`ifdef RETURN_ACK_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
  logic [CNT_W-1:0] ack_cnt;

  // Counter is zero on the first WAIT_ACK cycle since every other state clears it.
  always_ff @(posedge clk) begin
    if (!reset_n || state != WAIT_ACK) ack_cnt <= '0;
    else                               ack_cnt <= ack_cnt + 1'b1;
  end

  assign timeout = (state == WAIT_ACK) && (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      rem     <= '0;
      residue <= '0;
      sel     <= '0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_nx;
      rem     <= rem_nx;
      residue <= residue_nx;
      sel     <= sel_nx;
      fault_q <= fault_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    rem_nx     = rem;
    residue_nx = residue;
    sel_nx     = sel;
    fault_nx   = fault_q;

    bus.o_return_coin   = '0;
    bus.o_clear_balance = 1'b0;
    bus.o_busy          = (state != IDLE);
    bus.o_done          = 1'b0;
    bus.o_residue       = residue;
    bus.o_fault         = 1'b0;

    case (state)
      IDLE: begin
        if (trigger) begin
          rem_nx   = bus.i_balance;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        bus.o_clear_balance = 1'b1;
        state_nx            = SELECT;
      end
      SELECT: begin
        if (pick == '0) begin
          fault_nx = 1'b0;
          state_nx = DONE;
        end else begin
          sel_nx   = pick;
          state_nx = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        bus.o_return_coin = sel;
        if (bus.i_coin_ack) begin
          rem_nx   = rem - sel_val;
          state_nx = SELECT;
        end else if (timeout) begin
          // The coin that never got acked stays in rem and shows up as residue.
          fault_nx = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        bus.o_done    = 1'b1;
        bus.o_residue = rem;
        bus.o_fault   = fault_q;
        residue_nx    = rem;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coin_return_dispenser.sv
// Directed scoreboard bench: stimulus queues expected clear/coin/done events,
// a negedge monitor pops and compares as the dispenser produces them.
module tb_coin_return_dispenser;

  localparam int KCLR  = 0;
  localparam int KCOIN = 1;
  localparam int KDONE = 2;

  typedef struct {
    int          kind;
    logic [31:0] val;
    logic        flt;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n;
  logic drv_ack = 1'b0;
  logic force_ack = 1'b0;
  logic acked_q = 1'b0;
  logic [2:0] prev_coin = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_delay = 0;
  int ack_limit = 1 << 30;
  int acks_given = 0;
  int wait_cnt = 0;

  ev_t sbq[$];

  coin_return_dispenser_if #(.NUM_COINS(3)) bus ();

  assign bus.i_coin_ack = drv_ack | force_ack;

  coin_return_dispenser #(
    .NUM_COINS(3), .COIN0_VALUE(100), .COIN1_VALUE(500), .COIN2_VALUE(1000), .ACK_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] val, input logic flt);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.flt  = flt;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input string name, input int kind, input logic [31:0] val,
                        input logic flt);
    ev_t e;
    if (sbq.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_%s: got %0d expected no event at %0t", name, val, $time);
    end else begin
      e = sbq.pop_front();
      chk({name, "_kind"}, 32'(kind), 32'(e.kind));
      chk({name, "_value"}, val, e.val);
      if (kind == KDONE) chk("fault_flag", 32'(flt), 32'(e.flt));
    end
  endtask

  // Hopper model: acks after ack_delay waiting cycles, up to ack_limit acks in total.
  always @(negedge clk) begin
    if (bus.o_return_coin != 3'b000) begin
      if (wait_cnt >= ack_delay && acks_given < ack_limit && !drv_ack) begin
        drv_ack = 1'b1;
        acks_given++;
      end else if (!drv_ack) begin
        wait_cnt++;
      end
    end else begin
      drv_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  always @(posedge clk) acked_q <= reset_n && bus.i_coin_ack && (bus.o_return_coin != 3'b000);

  always @(negedge clk) begin
    if (bus.o_clear_balance) sb_pop("clear", KCLR, 32'd0, 1'b0);
    if (bus.o_return_coin != 3'b000 && prev_coin == 3'b000)
      sb_pop("coin", KCOIN, 32'(bus.o_return_coin), 1'b0);
    else if (bus.o_return_coin != 3'b000)
      chk("coin_stable", 32'(bus.o_return_coin), 32'(prev_coin));
    if (acked_q) chk("coin_drop_after_ack", 32'(bus.o_return_coin), 32'd0);
    if (bus.o_done) sb_pop("done", KDONE, bus.o_residue, bus.o_fault);
    prev_coin = bus.o_return_coin;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_coin"},  32'(bus.o_return_coin), 32'd0);
    chk({name, "_clear"}, 32'(bus.o_clear_balance), 32'd0);
    chk({name, "_busy"},  32'(bus.o_busy), 32'd0);
    chk({name, "_done"},  32'(bus.o_done), 32'd0);
    chk({name, "_residue"}, bus.o_residue, 32'd0);
    chk({name, "_fault"}, 32'(bus.o_fault), 32'd0);
  endtask

  // Applies a one-cycle trigger; returns at the negedge of the LOAD cycle.
  task automatic trig(input logic [31:0] bal, input bit use_req);
    bus.i_balance = bal;
    if (use_req) bus.i_return_req = 1'b1;
    else         bus.i_wait_time  = 32'd0;
    cyc(1);
    bus.i_return_req = 1'b0;
    bus.i_wait_time  = 32'd5;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (bus.o_busy && n < budget) begin
      cyc(1);
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, n);
    end
    cyc(1);
    chk({name, "_sb_empty"}, 32'(sbq.size()), 32'd0);
    bus.i_balance = 32'd0;
  endtask

  initial begin
    int n;
    reset_n          = 1'b0;
    bus.i_wait_time  = 32'd5;
    bus.i_return_req = 1'b0;
    bus.i_balance    = 32'd0;
    cyc(3);
    chk_all_zero("reset_held");
    reset_n = 1'b1;
    cyc(1);
    chk_all_zero("after_reset");

    // 1700 on timeout: 1000, 500, 100, 100, no residue; check T+1..T+3 timing.
    push(KCLR, 0, 0); push(KCOIN, 3'b100, 0); push(KCOIN, 3'b010, 0);
    push(KCOIN, 3'b001, 0); push(KCOIN, 3'b001, 0); push(KDONE, 0, 0);
    trig(32'd1700, 1'b0);
    chk("t1_busy_in_load", 32'(bus.o_busy), 32'd1);
    chk("t1_clear_in_load", 32'(bus.o_clear_balance), 32'd1);
    cyc(1);
    chk("t1_no_coin_in_select", 32'(bus.o_return_coin), 32'd0);
    cyc(1);
    chk("t1_first_coin_t3", 32'(bus.o_return_coin), 32'b100);
    wait_idle("t1", 60);

    // 250 on explicit request: 100, 100, residue 50.
    push(KCLR, 0, 0); push(KCOIN, 3'b001, 0); push(KCOIN, 3'b001, 0); push(KDONE, 50, 0);
    trig(32'd250, 1'b1);
    wait_idle("t2", 60);

    // Zero balance with either trigger, then both together: nothing happens.
    bus.i_balance   = 32'd0;
    bus.i_wait_time = 32'd0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("t3_busy_wait0", 32'(bus.o_busy), 32'd0);
    end
    bus.i_wait_time  = 32'd5;
    bus.i_return_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("t3_busy_req", 32'(bus.o_busy), 32'd0);
    end
    bus.i_return_req = 1'b0;
    cyc(2);

    // 500 with ack withheld 3 cycles; then stray acks while idle.
    ack_delay = 3;
    push(KCLR, 0, 0); push(KCOIN, 3'b010, 0); push(KDONE, 0, 0);
    trig(32'd500, 1'b0);
    wait_idle("t4", 60);
    ack_delay = 0;
    force_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("t4_idle_ack_busy", 32'(bus.o_busy), 32'd0);
    end
    force_ack = 1'b0;
    cyc(1);

    // 1600 with both triggers at once; reset during the second coin.
    ack_limit = acks_given + 1;
    push(KCLR, 0, 0); push(KCOIN, 3'b100, 0); push(KCOIN, 3'b010, 0);
    bus.i_return_req = 1'b1;
    trig(32'd1600, 1'b0);
    n = 0;
    while (bus.o_return_coin != 3'b010 && n < 30) begin
      cyc(1);
      n++;
    end
    chk("t5_second_coin_seen", 32'(bus.o_return_coin), 32'b010);
    cyc(1);
    reset_n = 1'b0;
    cyc(1);
    chk_all_zero("t5_mid_reset");
    reset_n   = 1'b1;
    ack_limit = 1 << 30;
    chk("t5_sb_empty", 32'(sbq.size()), 32'd0);
    cyc(1);
    push(KCLR, 0, 0); push(KCOIN, 3'b001, 0); push(KDONE, 0, 0);
    trig(32'd100, 1'b1);
    wait_idle("t5b", 40);

`ifdef RETURN_ACK_TIMEOUT_EN
    // 600: first coin acked, second never; 16-cycle timeout with residue 100.
    ack_limit = acks_given + 1;
    push(KCLR, 0, 0); push(KCOIN, 3'b010, 0); push(KCOIN, 3'b001, 0); push(KDONE, 100, 1);
    trig(32'd600, 1'b0);
    n = 0;
    while (bus.o_return_coin != 3'b001 && n < 30) begin
      cyc(1);
      n++;
    end
    n = 0;
    while (bus.o_return_coin == 3'b001 && n < 100) begin
      n++;
      cyc(1);
    end
    chk("t6_timeout_cycles", 32'(n), 32'd16);
    chk("t6_done_with_fault", 32'({bus.o_done, bus.o_fault}), 32'b11);
    wait_idle("t6", 40);
    ack_limit = 1 << 30;
`endif

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
